// File: rtl/prio_arb_rr_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// master = arbiter side (drives the grant), slave = requester/consumer side.
interface prio_arb_rr_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot
  );
endinterface

// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter: fixed priority (MODE 0, highest index) or round-robin (MODE 1).
// Latency 1 clk req->grant; grant held until gnt_ready, then re-arbitrated on the same edge.
module prio_arb_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  prio_arb_rr_if.master bus
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     oh_q, oh_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             handshake;
  logic [IDX_W-1:0] ptr_rot;
  logic [IDX_W-1:0] sel_ptr;
  logic [2*N-1:0]   req2;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

  assign handshake = (state_q == GRANT) && bus.gnt_ready;
  // Just-granted requester becomes lowest priority: scan restarts one below it.
  assign ptr_rot   = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
  assign sel_ptr   = handshake ? ptr_rot : ptr_q;
  assign req2      = {bus.req, bus.req};

  always_comb begin
    win_vld = |bus.req;
    win_idx = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) win_idx = IDX_W'(i);
      end
    end else begin
      // Window (sel_ptr, sel_ptr+N] of the doubled vector: highest hit is the
      // first requester found scanning down from sel_ptr with wrap.
      for (int j = 0; j < 2 * N; j++) begin
        if (j > int'(sel_ptr) && j <= int'(sel_ptr) + N && req2[j]) begin
          win_idx = IDX_W'(j % N);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          vld_d   = 1'b1;
          idx_d   = win_idx;
          oh_d    = N'(1) << win_idx;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          if (MODE == 1) ptr_d = ptr_rot;
          if (win_vld) begin
            idx_d = win_idx;
            oh_d  = N'(1) << win_idx;
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        oh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= IDX_W'(N - 1);
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_valid  = vld_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = oh_q;

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(oh_q));
  a_oh_zero_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !vld_q |-> (oh_q == '0));
  a_ready_ignored_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !vld_q |=> $stable(ptr_q));
endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed bench for prio_arb_rr: one fixed-priority and one round-robin instance, N=8.
module tb_prio_arb_rr;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  prio_arb_rr_if #(.N(8)) b0 ();
  prio_arb_rr_if #(.N(8)) b1 ();

  prio_arb_rr #(.N(8), .MODE(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  prio_arb_rr #(.N(8), .MODE(1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dut;
    bit         do_rst;
    logic [7:0] req;
    bit         rdy;
    bit         exp_vld;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit dut, bit do_rst, logic [7:0] req, bit rdy,
                              bit exp_vld, logic [2:0] exp_idx);
    vec_t v;
    v.dut = dut; v.do_rst = do_rst; v.req = req; v.rdy = rdy;
    v.exp_vld = exp_vld; v.exp_idx = exp_idx;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, bit dut, bit e_vld, logic [2:0] e_idx);
    logic [7:0] e_oh;
    e_oh = e_vld ? (8'd1 << e_idx) : 8'd0;
    if (dut == 1'b0) begin
      chk({name, "_vld"}, 32'(b0.gnt_valid),  32'(e_vld));
      chk({name, "_idx"}, 32'(b0.gnt_idx),    32'(e_idx));
      chk({name, "_oh"},  32'(b0.gnt_onehot), 32'(e_oh));
    end else begin
      chk({name, "_vld"}, 32'(b1.gnt_valid),  32'(e_vld));
      chk({name, "_idx"}, 32'(b1.gnt_idx),    32'(e_idx));
      chk({name, "_oh"},  32'(b1.gnt_onehot), 32'(e_oh));
    end
  endtask

  initial begin
    // Idle after reset, req=0
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 3'd0);
    // Fixed encode, back-to-back
    add(0, 0, 8'h01, 1, 1, 3'd0);
    add(0, 0, 8'h04, 1, 1, 3'd2);
    add(0, 0, 8'h10, 1, 1, 3'd4);
    add(0, 0, 8'h40, 1, 1, 3'd6);
    for (int i = 0; i < 3; i++) add(0, 0, 8'hA5, 1, 1, 3'd7);
    add(0, 0, 8'h00, 1, 0, 3'd7);
    // Sticky hold, then release
    for (int i = 0; i < 4; i++) add(0, 0, 8'h10, 0, 1, 3'd4);
    for (int i = 0; i < 2; i++) add(0, 0, 8'h80, 0, 1, 3'd4);
    add(0, 0, 8'h80, 1, 1, 3'd7);
    add(0, 0, 8'h00, 1, 0, 3'd7);
    // Round-robin full contention
    add(1, 1, 8'hFF, 1, 1, 3'd7);
    for (int k = 6; k >= 0; k--) add(1, 0, 8'hFF, 1, 1, 3'(k));
    add(1, 0, 8'hFF, 1, 1, 3'd7);
    // Round-robin sparse wrap
    add(1, 1, 8'h82, 1, 1, 3'd7);
    add(1, 0, 8'h82, 1, 1, 3'd1);
    add(1, 0, 8'h82, 1, 1, 3'd7);
    add(1, 0, 8'h82, 1, 1, 3'd1);
    add(1, 0, 8'h00, 1, 0, 3'd1);

    // Reset with requests active: outputs held at zero
    rst_n = 1'b0;
    b0.req = 8'hFF; b0.gnt_ready = 1'b1;
    b1.req = 8'hFF; b1.gnt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst_fix", 0, 0, 3'd0);
    chk_out("rst_rr",  1, 0, 3'd0);
    @(negedge clk);
    b0.req = 8'h00; b0.gnt_ready = 1'b0;
    b1.req = 8'h00; b1.gnt_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].do_rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      if (vecs[i].dut == 1'b0) begin
        b0.req = vecs[i].req; b0.gnt_ready = vecs[i].rdy;
        b1.req = 8'h00;       b1.gnt_ready = 1'b0;
      end else begin
        b1.req = vecs[i].req; b1.gnt_ready = vecs[i].rdy;
        b0.req = 8'h00;       b0.gnt_ready = 1'b0;
      end
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].dut, vecs[i].exp_vld, vecs[i].exp_idx);
    end

    // Reset mid-grant: round-robin instance holding index 5
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    b1.req = 8'h20; b1.gnt_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_out("mid_hold", 1, 1, 3'd5);
    @(posedge clk);
    #1;
    chk_out("mid_hold2", 1, 1, 3'd5);
    @(negedge clk);
    b1.req = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1, 0, 3'd0);
    #1;
    b1.gnt_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post_rst", 1, 1, 3'd7);
    @(posedge clk);
    #1;
    chk_out("post_rst2", 1, 1, 3'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
